uc: RTL and testbench

Control unit for the single-cycle microcontroller datapath: consumes the 6-bit `Opcode` and the registered zero flag `z` from the datapath and drives its control inputs (`s_inc`, `s_inm`, `we3`, `wez`, `Op`). Decoding is combinational so the datapath keeps one instruction per cycle. A small state machine adds the sequential behaviour: conditional skip-next instructions, a terminal HALT state, and a saturating retired-instruction counter for debug. Sits beside the datapath in the top-level CPU wrapper.

---
 rtl/uc_pkg.sv | 20 ++
 rtl/uc_sat_counter.sv | 28 ++
 rtl/uc.sv | 111 +++++++++++
 tb/tb_uc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller control unit: opcode classes
// taken from Opcode[5:2] and the sequencing state encoding.
package uc_pkg;

  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_SKZ  = 4'b1100;
  localparam logic [3:0] OP_SKNZ = 4'b1101;
  localparam logic [3:0] OP_NOP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SKIP   = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/uc_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;
  logic          w_full;

  assign w_full  = (r_count == {CW{1'b1}});
  assign o_count = r_count;

  // count register, frozen once it reaches its maximum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en && !w_full) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/uc.sv
// Control unit: combinational instruction decode plus a RUN/SKIP/HALTED
// sequencer and a saturating retired-instruction counter.
module uc
  import uc_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    Opcode,
  input  logic          z,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic [2:0]    Op,
  output logic          halted,
  output logic          skipping,
  output logic [CW-1:0] n_retired
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_cls;
  logic       w_retire;
  logic       w_unused_bits;

  assign w_cls         = Opcode[5:2];
  assign w_unused_bits = ^Opcode[1:0];

  // sequencing state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // decode and next-state; reset forces a harmless PC+1 with no writes
  always_comb begin
    s_inc        = 1'b1;
    s_inm        = 1'b0;
    we3          = 1'b0;
    wez          = 1'b0;
    Op           = 3'b000;
    w_next_state = RUN;
    if (reset) begin
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_cls[3]) begin
            Op  = w_cls[2:0];
            we3 = 1'b1;
            wez = 1'b1;
          end else begin
            case (w_cls)
              OP_LI: begin
                s_inm = 1'b1;
                we3   = 1'b1;
              end
              OP_J:    s_inc = 1'b0;
              OP_JZ:   s_inc = ~z;
              OP_JNZ:  s_inc = z;
              OP_SKZ: begin
                if (z) begin
                  w_next_state = SKIP;
                end else begin
                  w_next_state = RUN;
                end
              end
              OP_SKNZ: begin
                if (!z) begin
                  w_next_state = SKIP;
                end else begin
                  w_next_state = RUN;
                end
              end
              OP_NOP:  s_inc = 1'b1;
              OP_HALT: begin
                s_inc        = 1'b0;
                w_next_state = HALTED;
              end
              default: w_next_state = RUN;
            endcase
          end
        end
        // squashed slot: opcode ignored, always resume
        SKIP:    w_next_state = RUN;
        HALTED: begin
          s_inc        = 1'b0;
          w_next_state = HALTED;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  assign halted   = (r_state == HALTED);
  assign skipping = (r_state == SKIP);
  assign w_retire = (r_state == RUN) && !reset;

  sat_counter #(.CW(CW)) u_retired (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_retire),
    .o_count (n_retired)
  );

endmodule

// File: tb/tb_uc.sv
// Self-checking bench for uc: directed scenarios plus randomized opcodes,
// checked against an instruction-level reference model.
module tb_uc;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zf;

  logic        s_inc_a, s_inm_a, we3_a, wez_a, halted_a, skipping_a;
  logic [2:0]  op_a;
  logic [15:0] n_a;
  logic        s_inc_b, s_inm_b, we3_b, wez_b, halted_b, skipping_b;
  logic [2:0]  op_b;
  logic [3:0]  n_b;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 = running, 1 = skipping, 2 = halted
  int m_mode = 0;
  int m_cnt16 = 0;
  int m_cnt4 = 0;

  always #5 clk = ~clk;

  uc #(.CW(16)) u_a (
    .clk(clk), .reset(reset), .Opcode(opcode), .z(zf),
    .s_inc(s_inc_a), .s_inm(s_inm_a), .we3(we3_a), .wez(wez_a), .Op(op_a),
    .halted(halted_a), .skipping(skipping_a), .n_retired(n_a)
  );

  uc #(.CW(4)) u_b (
    .clk(clk), .reset(reset), .Opcode(opcode), .z(zf),
    .s_inc(s_inc_b), .s_inm(s_inm_b), .we3(we3_b), .wez(wez_b), .Op(op_b),
    .halted(halted_b), .skipping(skipping_b), .n_retired(n_b)
  );

  wire [6:0] ctrl_a = {s_inc_a, s_inm_a, we3_a, wez_a, op_a};
  wire [6:0] ctrl_b = {s_inc_b, s_inm_b, we3_b, wez_b, op_b};
  wire [1:0] stat_a = {halted_a, skipping_a};

  // expected {s_inc, s_inm, we3, wez, Op} from the instruction table
  function automatic logic [6:0] exp_ctrl(input logic [5:0] o, input logic zz, input int mode);
    int k;
    k = int'(o[5:2]);
    if (mode == 2) return 7'b0000000;
    if (mode == 1) return 7'b1000000;
    if (k < 8)   return {4'b1011, o[4:2]};
    if (k == 8)  return 7'b1110000;
    if (k == 9)  return 7'b0000000;
    if (k == 10) return {~zz, 6'b000000};
    if (k == 11) return {zz, 6'b000000};
    if (k == 15) return 7'b0000000;
    return 7'b1000000;
  endfunction

  function automatic int nxt(input int mode, input logic [5:0] o, input logic zz);
    if (mode == 2) return 2;
    if (mode == 1) return 0;
    if (o[5:2] == 4'd12) return zz ? 1 : 0;
    if (o[5:2] == 4'd13) return zz ? 0 : 1;
    if (o[5:2] == 4'd15) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] exp_stat(input int mode);
    return {mode == 2, mode == 1};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (m_mode == 0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_mode = nxt(m_mode, opcode, zf);
    end
    #1;
  endtask

  task automatic apply(input logic [5:0] o, input logic zz);
    opcode = o;
    zf     = zz;
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    m_mode = 0; m_cnt16 = 0; m_cnt4 = 0;
    n_vec++;
    if ({stat_a, n_a} !== {2'b00, 16'd0} || n_b !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: stat=%b n16=%0d n4=%0d want 00/0/0", stat_a, n_a, n_b);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b011000; zf = 1'b0;
    #3;
    n_vec++;
    if ({s_inc_a, we3_a, wez_a} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100", {s_inc_a, we3_a, wez_a});
    end
    tick(); tick();
    n_vec++;
    if ({stat_a, n_a, n_b} !== 22'd0) begin
      n_err++; $display("FAIL reset_state: stat=%b n16=%0d n4=%0d want 0", stat_a, n_a, n_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    apply(6'b011000, 1'b0);
    n_vec++;
    if (ctrl_a !== exp_ctrl(opcode, zf, m_mode)) begin
      n_err++; $display("FAIL alu_ctrl: got %b want %b", ctrl_a, exp_ctrl(opcode, zf, m_mode));
    end
    tick();
    n_vec++;
    if (n_a !== 16'(m_cnt16) || m_cnt16 != 1) begin
      n_err++; $display("FAIL alu_count: got %0d want 1", n_a);
    end
  endtask

  task automatic test_li_j();
    apply(6'b100000, 1'b1);
    n_vec++;
    if (ctrl_a !== exp_ctrl(opcode, zf, m_mode)) begin
      n_err++; $display("FAIL li_ctrl: got %b want %b", ctrl_a, exp_ctrl(opcode, zf, m_mode));
    end
    tick();
    apply(6'b100111, 1'b0);
    n_vec++;
    if (ctrl_a !== exp_ctrl(opcode, zf, m_mode)) begin
      n_err++; $display("FAIL j_ctrl: got %b want %b", ctrl_a, exp_ctrl(opcode, zf, m_mode));
    end
    tick();
  endtask

  task automatic test_jumps();
    for (int i = 0; i < 4; i++) begin
      apply(i < 2 ? 6'b101000 : 6'b101100, i[0]);
      n_vec++;
      if (ctrl_a !== exp_ctrl(opcode, zf, m_mode)) begin
        n_err++;
        $display("FAIL jump_ctrl op=%b z=%b: got %b want %b", opcode, zf, ctrl_a, exp_ctrl(opcode, zf, m_mode));
      end
      tick();
    end
  endtask

  task automatic test_skz();
    apply(6'b110000, 1'b1);
    tick();
    apply(6'b000100, 1'b0);
    n_vec++;
    if ({stat_a, ctrl_a} !== {2'b01, 7'b1000000} || exp_stat(m_mode) !== 2'b01) begin
      n_err++; $display("FAIL skz_squash: stat=%b ctrl=%b want 01/1000000", stat_a, ctrl_a);
    end
    tick();
    n_vec++;
    if (n_a !== 16'(m_cnt16)) begin
      n_err++; $display("FAIL skz_count: got %0d want %0d", n_a, m_cnt16);
    end
    apply(6'b000100, 1'b0);
    n_vec++;
    if ({stat_a, ctrl_a} !== {exp_stat(m_mode), exp_ctrl(opcode, zf, m_mode)}) begin
      n_err++; $display("FAIL skz_resume: stat=%b ctrl=%b want %b/%b", stat_a, ctrl_a, exp_stat(m_mode), exp_ctrl(opcode, zf, m_mode));
    end
    tick();
    apply(6'b110001, 1'b0);
    tick();
    n_vec++;
    if (stat_a !== exp_stat(m_mode)) begin
      n_err++; $display("FAIL skz_not_taken: stat=%b want %b", stat_a, exp_stat(m_mode));
    end
  endtask

  task automatic test_sknz_halt();
    apply(6'b110100, 1'b0);
    tick();
    apply(6'b111100, 1'b0);
    tick();
    n_vec++;
    if (stat_a !== 2'b00 || exp_stat(m_mode) !== 2'b00) begin
      n_err++; $display("FAIL squashed_halt: stat=%b want 00", stat_a);
    end
    apply(6'b111000, 1'b1);
    tick();
    apply(6'b111110, 1'b1);
    n_vec++;
    if (s_inc_a !== 1'b0) begin
      n_err++; $display("FAIL halt_sinc: got %b want 0", s_inc_a);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      n_vec++;
      if ({halted_a, s_inc_a, we3_a, wez_a} !== 4'b1000 || n_a !== 16'(m_cnt16) || m_mode != 2) begin
        n_err++;
        $display("FAIL halted_hold %0d: h/sinc/we3/wez=%b n=%0d want 1000 n=%0d", i, {halted_a, s_inc_a, we3_a, wez_a}, n_a, m_cnt16);
      end
      tick();
    end
    pulse_reset();
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      apply({4'b1110, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)));
      tick();
    end
    n_vec++;
    if (n_b !== 4'd15 || n_a !== 16'd20 || m_cnt4 != 15) begin
      n_err++; $display("FAIL saturation: n4=%0d n16=%0d want 15/20", n_b, n_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        pulse_reset();
      end else begin
        apply(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        n_vec++;
        if (ctrl_a !== exp_ctrl(opcode, zf, m_mode) || ctrl_b !== exp_ctrl(opcode, zf, m_mode) ||
            stat_a !== exp_stat(m_mode) || {halted_b, skipping_b} !== exp_stat(m_mode)) begin
          n_err++;
          $display("FAIL random %0d op=%b z=%b: ctrl=%b/%b stat=%b want ctrl=%b stat=%b",
                   i, opcode, zf, ctrl_a, ctrl_b, stat_a, exp_ctrl(opcode, zf, m_mode), exp_stat(m_mode));
        end
        tick();
        n_vec++;
        if (n_a !== 16'(m_cnt16) || n_b !== 4'(m_cnt4)) begin
          n_err++; $display("FAIL random_count %0d: n16=%0d n4=%0d want %0d/%0d", i, n_a, n_b, m_cnt16, m_cnt4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_li_j();
    test_jumps();
    test_skz();
    test_sknz_halt();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
